// File: rtl/aliens_formation_pkg.sv
// Shared definitions for the alien formation sequencer.
// Holds the default playfield geometry, the colour codes used by the
// render logic, the sequencer state encoding and the Length() helper.
package aliens_formation_pkg;

  localparam int DEF_ALIENS_WIDTH  = 20;
  localparam int DEF_ALIENS_HEIGHT = 10;
  localparam int DEF_X_MIN         = 0;
  localparam int DEF_X_MAX         = 639;
  localparam int DEF_Y_LIMIT       = 440;

  typedef enum logic [2:0] {
    BACKGROUND = 3'd0,
    ALIENS0    = 3'd1,
    ALIENS1    = 3'd2,
    ALIENS2    = 3'd3,
    ALIENS3    = 3'd4
  } colour_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of bits needed to hold the values 0..n-1 (never less than one).
  function automatic int Length(input int n);
    int bits = 1;
    while ((1 << bits) < n) bits = bits + 1;
    return bits;
  endfunction

endpackage

// File: rtl/aliens_formation_ctrl_extent.sv
// Combinational extent finder for the alien grid.
// Ports:
//   i_alive     alive mask, bit i*NB_COL+j
//   o_jmin      lowest column holding a live alien
//   o_jmax      highest column holding a live alien
//   o_imax      highest row holding a live alien
//   o_any_alive at least one alien is alive
// With an empty mask the indices read as zero.
module aliens_extent
  import aliens_formation_pkg::*;
#(
  parameter int NB_COL = 6,
  parameter int NB_LIN = 4
) (
  input  logic [NB_LIN*NB_COL-1:0]  i_alive,
  output logic [Length(NB_COL)-1:0] o_jmin,
  output logic [Length(NB_COL)-1:0] o_jmax,
  output logic [Length(NB_LIN)-1:0] o_imax,
  output logic                      o_any_alive
);

  localparam int COL_W = Length(NB_COL);
  localparam int LIN_W = Length(NB_LIN);

  logic [NB_COL-1:0] w_colAny;
  logic [NB_LIN-1:0] w_rowAny;

  // Collapse the mask into per-column and per-row occupancy flags.
  always_comb begin
    w_colAny = '0;
    w_rowAny = '0;
    for (int i = 0; i < NB_LIN; i++) begin
      for (int j = 0; j < NB_COL; j++) begin
        if (i_alive[i*NB_COL+j]) begin
          w_colAny[j] = 1'b1;
          w_rowAny[i] = 1'b1;
        end
      end
    end
  end

  // Scan downwards for the lowest column, upwards for the highest ones.
  always_comb begin
    o_jmin = '0;
    o_jmax = '0;
    o_imax = '0;
    for (int j = NB_COL - 1; j >= 0; j--) begin
      if (w_colAny[j]) o_jmin = COL_W'(j);
    end
    for (int j = 0; j < NB_COL; j++) begin
      if (w_colAny[j]) o_jmax = COL_W'(j);
    end
    for (int i = 0; i < NB_LIN; i++) begin
      if (w_rowAny[i]) o_imax = LIN_W'(i);
    end
  end

  assign o_any_alive = |w_colAny;

endmodule

// File: rtl/aliens_formation_ctrl.sv
// Alien formation sequencer: owns the formation origin, the alive mask and
// the march direction; steps the grid on frame ticks, descends and reverses
// at the screen edges, clears aliens on hits and speeds up as they die.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   i_start         pulse: reload formation and run
//   i_frame_tick    pulse per video frame
//   i_hit_valid     pulse: alien i_hit_index destroyed
//   i_hit_index     alien index i*NB_COL+j
//   o_x_alien       centre x of alien (0,0), signed
//   o_y_alien       centre y of alien (0,0)
//   o_alive         alive mask
//   o_dir_left      1 = marching left
//   o_move_pulse    pulse alongside every step or descent
//   o_wave_clear    pulse when the last alien dies
//   o_invaded       sticky, formation reached the invasion line
module aliens_formation_ctrl
  import aliens_formation_pkg::*;
#(
  parameter int NB_COL        = 6,
  parameter int NB_LIN        = 4,
  parameter int ALIENS_WIDTH  = DEF_ALIENS_WIDTH,
  parameter int ALIENS_HEIGHT = DEF_ALIENS_HEIGHT,
  parameter int STEP_H        = 4,
  parameter int STEP_V        = 10,
  parameter int X_INIT        = 40,
  parameter int Y_INIT        = 40,
  parameter int X_MIN         = DEF_X_MIN,
  parameter int X_MAX         = DEF_X_MAX,
  parameter int Y_LIMIT       = DEF_Y_LIMIT,
  parameter int MOVE_FRAMES   = 30,
  parameter int MIN_FRAMES    = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_start,
  input  logic                              i_frame_tick,
  input  logic                              i_hit_valid,
  input  logic [Length(NB_LIN*NB_COL)-1:0]  i_hit_index,
  output logic signed [9:0]                 o_x_alien,
  output logic [9:0]                        o_y_alien,
  output logic [NB_LIN*NB_COL-1:0]          o_alive,
  output logic                              o_dir_left,
  output logic                              o_move_pulse,
  output logic                              o_wave_clear,
  output logic                              o_invaded
);

  localparam int NB_ALIENS = NB_LIN * NB_COL;
  localparam int COL_W     = Length(NB_COL);
  localparam int LIN_W     = Length(NB_LIN);
  localparam int CNT_W     = Length(MOVE_FRAMES);
  localparam int KILL_W    = Length(NB_ALIENS + 1);

  state_t                 r_state, w_stateNext;
  logic signed [9:0]      r_xAlien, w_xNext;
  logic [9:0]             r_yAlien, w_yNext;
  logic [NB_ALIENS-1:0]   r_alive, w_aliveNext;
  logic                   r_dirLeft, w_dirNext;
  logic                   r_movePulse, w_movePulseNext;
  logic                   r_waveClear, w_waveClearNext;
  logic                   r_invaded, w_invadedNext;
  logic [CNT_W-1:0]       r_frameCnt, w_frameCntNext;
  logic [KILL_W-1:0]      r_kills, w_killsNext;

  logic [COL_W-1:0]       w_jmin, w_jmax;
  logic [LIN_W-1:0]       w_imax;
  logic                   w_anyAlive;
  logic signed [11:0]     w_leftEdge, w_rightEdge, w_bottom;
  logic [NB_ALIENS-1:0]   w_hitMask;
  logic                   w_hitOk, w_lastKill, w_descend;
  int                     w_period;

  aliens_extent #(
    .NB_COL (NB_COL),
    .NB_LIN (NB_LIN)
  ) u_extent (
    .i_alive     (r_alive),
    .o_jmin      (w_jmin),
    .o_jmax      (w_jmax),
    .o_imax      (w_imax),
    .o_any_alive (w_anyAlive)
  );

  // Edges come from the registered mask, so a same-cycle hit never
  // changes the geometry the move decision is based on.
  assign w_leftEdge  = 12'(r_xAlien) - 12'(ALIENS_WIDTH / 2)
                     + 12'(2 * ALIENS_WIDTH * int'(w_jmin));
  assign w_rightEdge = 12'(r_xAlien) + 12'(ALIENS_WIDTH / 2)
                     + 12'(2 * ALIENS_WIDTH * int'(w_jmax));
  assign w_bottom    = $signed({2'b00, r_yAlien}) + 12'(ALIENS_HEIGHT / 2)
                     + 12'(2 * ALIENS_HEIGHT * int'(w_imax));

  // Indices beyond the grid shift the bit out and leave an empty mask.
  assign w_hitMask = NB_ALIENS'(1) << i_hit_index;

  // Next-state and next-output logic; start overrides hits and ticks.
  always_comb begin
    w_stateNext     = r_state;
    w_xNext         = r_xAlien;
    w_yNext         = r_yAlien;
    w_aliveNext     = r_alive;
    w_dirNext       = r_dirLeft;
    w_movePulseNext = 1'b0;
    w_waveClearNext = 1'b0;
    w_invadedNext   = r_invaded;
    w_frameCntNext  = r_frameCnt;
    w_killsNext     = r_kills;
    w_hitOk         = 1'b0;
    w_lastKill      = 1'b0;
    w_descend       = 1'b0;

    w_period = MOVE_FRAMES - int'(r_kills);
    if (w_period < MIN_FRAMES) w_period = MIN_FRAMES;

    if (i_start) begin
      w_stateNext    = RUN;
      w_xNext        = 10'(X_INIT);
      w_yNext        = 10'(Y_INIT);
      w_aliveNext    = '1;
      w_dirNext      = 1'b0;
      w_invadedNext  = 1'b0;
      w_frameCntNext = '0;
      w_killsNext    = '0;
    end else if (r_state == RUN) begin
      w_hitOk = i_hit_valid && |(r_alive & w_hitMask);
      if (w_hitOk) begin
        w_aliveNext = r_alive & ~w_hitMask;
        if (int'(r_kills) < NB_ALIENS) w_killsNext = r_kills + KILL_W'(1);
      end
      w_lastKill = w_hitOk && (w_aliveNext == '0);

      if (w_lastKill) begin
        w_waveClearNext = 1'b1;
        w_stateNext     = DONE;
      end else if (i_frame_tick && w_anyAlive) begin
        if (int'(r_frameCnt) + 1 >= w_period) begin
          w_frameCntNext  = '0;
          w_movePulseNext = 1'b1;
          if (!r_dirLeft) begin
            if (w_rightEdge + 12'(STEP_H) > 12'(X_MAX)) begin
              w_descend = 1'b1;
              w_dirNext = 1'b1;
            end else begin
              w_xNext = r_xAlien + 10'(STEP_H);
            end
          end else begin
            if (w_leftEdge - 12'(STEP_H) < 12'(X_MIN)) begin
              w_descend = 1'b1;
              w_dirNext = 1'b0;
            end else begin
              w_xNext = r_xAlien - 10'(STEP_H);
            end
          end
          if (w_descend) begin
            w_yNext = r_yAlien + 10'(STEP_V);
            if (w_bottom + 12'(STEP_V) >= 12'(Y_LIMIT)) begin
              w_invadedNext = 1'b1;
              w_stateNext   = DONE;
            end
          end
        end else begin
          w_frameCntNext = r_frameCnt + CNT_W'(1);
        end
      end
    end
  end

  // State and formation registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_xAlien    <= 10'(X_INIT);
      r_yAlien    <= 10'(Y_INIT);
      r_alive     <= '1;
      r_dirLeft   <= 1'b0;
      r_movePulse <= 1'b0;
      r_waveClear <= 1'b0;
      r_invaded   <= 1'b0;
      r_frameCnt  <= '0;
      r_kills     <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_xAlien    <= w_xNext;
      r_yAlien    <= w_yNext;
      r_alive     <= w_aliveNext;
      r_dirLeft   <= w_dirNext;
      r_movePulse <= w_movePulseNext;
      r_waveClear <= w_waveClearNext;
      r_invaded   <= w_invadedNext;
      r_frameCnt  <= w_frameCntNext;
      r_kills     <= w_killsNext;
    end
  end

  assign o_x_alien    = r_xAlien;
  assign o_y_alien    = r_yAlien;
  assign o_alive      = r_alive;
  assign o_dir_left   = r_dirLeft;
  assign o_move_pulse = r_movePulse;
  assign o_wave_clear = r_waveClear;
  assign o_invaded    = r_invaded;

endmodule

// File: tb/tb_aliens_formation_ctrl.sv
// Scoreboard bench for aliens_formation_ctrl: expected moves / wave-clear
// events are queued by the stimulus process and consumed by a monitor
// whenever the DUT raises move_pulse or wave_clear.
module tb_aliens_formation_ctrl;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              frame_tick = 1'b0;
  logic              hit_valid = 1'b0;
  logic [4:0]        hit_index = '0;
  logic signed [9:0] x_alien;
  logic [9:0]        y_alien;
  logic [23:0]       alive;
  logic              dir_left, move_pulse, wave_clear, invaded;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       dirLeft;
    logic       movePulse;
    logic       waveClear;
    logic       invaded;
  } exp_t;

  exp_t expQ[$];
  int   assertCount = 0;
  int   failCount   = 0;

  aliens_formation_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (start),
    .i_frame_tick (frame_tick),
    .i_hit_valid  (hit_valid),
    .i_hit_index  (hit_index),
    .o_x_alien    (x_alien),
    .o_y_alien    (y_alien),
    .o_alive      (alive),
    .o_dir_left   (dir_left),
    .o_move_pulse (move_pulse),
    .o_wave_clear (wave_clear),
    .o_invaded    (invaded)
  );

  // 10 time-unit clock.
  always #5 clk = ~clk;

  // Monitor: every pulse must match the next queued expectation.
  initial begin : monitor
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clk);
      if (!reset && (move_pulse || wave_clear)) begin
        got = '{x: x_alien, y: y_alien, dirLeft: dir_left, movePulse: move_pulse,
                waveClear: wave_clear, invaded: invaded};
        assertCount++;
        if (expQ.size() == 0) begin
          failCount++;
          $display("[TB] FAIL unexpected_pulse: actual x=%0d y=%0d dir=%0b mp=%0b wc=%0b inv=%0b, required no pulse",
                   x_alien, y_alien, dir_left, move_pulse, wave_clear, invaded);
        end else begin
          e = expQ.pop_front();
          if (got !== e) begin
            failCount++;
            $display("[TB] FAIL scoreboard_event: actual x=%0d y=%0d dir=%0b mp=%0b wc=%0b inv=%0b, required x=%0d y=%0d dir=%0b mp=%0b wc=%0b inv=%0b",
                     x_alien, y_alien, dir_left, move_pulse, wave_clear, invaded,
                     $signed(e.x), e.y, e.dirLeft, e.movePulse, e.waveClear, e.invaded);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] required);
    assertCount++;
    if (actual !== required) begin
      failCount++;
      $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, required);
    end
  endtask

  // All stimulus tasks start and end one time unit after a rising edge.
  task automatic applyStimulus(input int nTicks);
    for (int k = 0; k < nTicks; k++) begin
      frame_tick = 1'b1;
      @(posedge clk); #1;
    end
    frame_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic sendStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic sendHit(input int idx);
    hit_valid = 1'b1;
    hit_index = 5'(idx);
    @(posedge clk); #1;
    hit_valid = 1'b0;
  endtask

  task automatic pushExp(input int x, input int y, input logic dl, input logic mp,
                         input logic wc, input logic inv);
    expQ.push_back('{x: 10'(x), y: 10'(y), dirLeft: dl, movePulse: mp,
                     waveClear: wc, invaded: inv});
  endtask

  task automatic drainCheck(input string name);
    idle(3);
    checkOutput(name, expQ.size(), 0);
  endtask

  initial begin : stimulus
    int  mx, my, nMoves;
    logic mdir, inv, desc;

    // Reset values
    idle(2);
    checkOutput("reset_x", x_alien, 40);
    checkOutput("reset_y", y_alien, 40);
    checkOutput("reset_alive", alive, 24'hFFFFFF);
    checkOutput("reset_dir", dir_left, 0);
    checkOutput("reset_move_pulse", move_pulse, 0);
    checkOutput("reset_wave_clear", wave_clear, 0);
    checkOutput("reset_invaded", invaded, 0);
    reset = 1'b0;
    idle(1);

    // First move exactly on the 30th tick
    $display("[TB] first move after 30 ticks");
    sendStart();
    applyStimulus(29);
    checkOutput("no_move_before_30", x_alien, 40);
    pushExp(44, 40, 0, 1, 0, 0);
    applyStimulus(1);
    drainCheck("first_move_queue");
    checkOutput("first_move_x", x_alien, 44);

    // March right to the edge and descend
    $display("[TB] full grid march to right edge");
    for (int k = 1; k <= 96; k++) pushExp(44 + 4 * k, 40, 0, 1, 0, 0);
    pushExp(428, 50, 1, 1, 0, 0);
    applyStimulus(97 * 30);
    drainCheck("march_right_queue");
    checkOutput("descent_x", x_alien, 428);
    checkOutput("descent_y", y_alien, 50);
    checkOutput("descent_dir", dir_left, 1);

    // Column 5 destroyed: reversal point shifts right by 40 px, period 26
    $display("[TB] column 5 destroyed");
    sendStart();
    sendHit(5); sendHit(11); sendHit(17); sendHit(23);
    checkOutput("col5_alive", alive, 24'h7DF7DF);
    for (int k = 1; k <= 107; k++) pushExp(40 + 4 * k, 40, 0, 1, 0, 0);
    pushExp(468, 50, 1, 1, 0, 0);
    applyStimulus(108 * 26);
    drainCheck("col5_queue");
    checkOutput("col5_reverse_x", x_alien, 468);

    // Duplicate and out-of-range hits count nothing
    $display("[TB] duplicate and out-of-range hits");
    sendStart();
    sendHit(3); sendHit(3); sendHit(30);
    checkOutput("dup_hit_alive", alive, 24'hFFFFF7);
    applyStimulus(28);
    drainCheck("period29_early_queue");
    pushExp(44, 40, 0, 1, 0, 0);
    applyStimulus(1);
    drainCheck("period29_queue");
    checkOutput("period29_x", x_alien, 44);

    // Kill every alien
    $display("[TB] wave clear");
    sendStart();
    for (int k = 0; k < 23; k++) sendHit(k);
    checkOutput("one_left_alive", alive, 24'h800000);
    pushExp(40, 40, 0, 0, 1, 0);
    sendHit(23);
    drainCheck("wave_clear_queue");
    checkOutput("cleared_alive", alive, 0);
    applyStimulus(40);
    sendHit(5);
    idle(2);
    checkOutput("done_x_frozen", x_alien, 40);
    checkOutput("done_y_frozen", y_alien, 40);
    checkOutput("done_wave_clear_low", wave_clear, 0);

    // Invasion: keep bottom corners (18, 23) so width stays full, period 8
    $display("[TB] invasion");
    sendStart();
    for (int k = 0; k < 24; k++) if (k != 18 && k != 23) sendHit(k);
    checkOutput("corners_alive", alive, 24'h840000);
    mx = 40; my = 40; mdir = 1'b0; inv = 1'b0; nMoves = 0;
    while (!inv && nMoves < 10000) begin
      nMoves++;
      desc = 1'b0;
      if (!mdir) begin
        if (mx + 10 + 200 + 4 > 639) begin desc = 1'b1; mdir = 1'b1; end
        else mx += 4;
      end else begin
        if (mx - 10 - 4 < 0) begin desc = 1'b1; mdir = 1'b0; end
        else mx -= 4;
      end
      if (desc) begin
        my += 10;
        if (my + 5 + 60 >= 440) inv = 1'b1;
      end
      pushExp(mx, my, mdir, 1, 0, inv);
    end
    applyStimulus(nMoves * 8);
    drainCheck("invasion_queue");
    checkOutput("invaded_set", invaded, 1);
    checkOutput("invaded_x", x_alien, 12);
    checkOutput("invaded_y", y_alien, 380);
    checkOutput("invaded_dir", dir_left, 0);
    applyStimulus(20);
    sendHit(18);
    idle(2);
    checkOutput("done_alive_held", alive, 24'h840000);
    checkOutput("done_y_held", y_alien, 380);
    checkOutput("invaded_sticky", invaded, 1);

    // Start clears invasion; asynchronous reset mid-RUN
    $display("[TB] reset during run");
    sendStart();
    checkOutput("start_clears_invaded", invaded, 0);
    sendHit(7);
    applyStimulus(28);
    pushExp(44, 40, 0, 1, 0, 0);
    applyStimulus(1);
    drainCheck("pre_reset_queue");
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_x", x_alien, 40);
    checkOutput("async_reset_alive", alive, 24'hFFFFFF);
    checkOutput("async_reset_y", y_alien, 40);
    checkOutput("async_reset_dir", dir_left, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);
    sendStart();
    applyStimulus(29);
    pushExp(44, 40, 0, 1, 0, 0);
    applyStimulus(1);
    drainCheck("resume_queue");
    checkOutput("resume_x", x_alien, 44);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
